// File: rtl/sequence_generator.sv
// Serial 01[0*]1 pattern transmitter with per-bit valid strobe and a 0-99
// completed-pattern counter shown on two active-low 7-segment digits.
module sequence_generator #(
    parameter int ZW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          start,
    input  logic [ZW-1:0] zeros,
    output logic          ready,
    output logic          busy,
    output logic          sig_out,
    output logic          sig_valid,
    output logic          done,
    output logic [6:0]    disp0,
    output logic [6:0]    disp1,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD0 = 3'd1,
        ONE1  = 3'd2,
        ZERO  = 3'd3,
        ONE2  = 3'd4
    } state_t;

    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    state_t        state, state_nxt;
    logic [ZW-1:0] zcnt, zcnt_nxt;
    logic [6:0]    count;
    logic [3:0]    ones, tens;
    logic          accept;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0011000;
            default: seg7 = 7'b0000111;
        endcase
    endfunction

    // Handshake: a request transfers on a rising edge where start, ready and
    // ena are all 1; ready is high in IDLE and in ONE2 so patterns can abut.
    assign ready     = (state == IDLE) || (state == ONE2);
    assign busy      = (state != IDLE);
    assign accept    = start && ready && ena;
    assign state_dbg = state;

    assign ones = 4'(count % 7'd10);
    assign tens = 4'(count / 7'd10);

    always_comb begin
        state_nxt = state;
        zcnt_nxt  = zcnt;
        if (ena) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_nxt = LEAD0;
                        zcnt_nxt  = zeros;
                    end
                end
                LEAD0: state_nxt = ONE1;
                ONE1:  state_nxt = (zcnt == '0) ? ONE2 : ZERO;
                ZERO: begin
                    if (zcnt > ZW'(1)) zcnt_nxt = zcnt - 1'b1;
                    else               state_nxt = ONE2;
                end
                ONE2: begin
                    if (accept) begin
                        state_nxt = LEAD0;
                        zcnt_nxt  = zeros;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Line outputs are registered from the next state so each bit lines up
    // with the cycle its state occupies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            zcnt      <= '0;
            count     <= '0;
            sig_out   <= 1'b0;
            sig_valid <= 1'b0;
            done      <= 1'b0;
            disp0     <= SEG_ZERO;
            disp1     <= SEG_ZERO;
        end else begin
            state <= state_nxt;
            zcnt  <= zcnt_nxt;
            if (ena) begin
                sig_valid <= (state_nxt != IDLE);
                sig_out   <= (state_nxt == ONE1) || (state_nxt == ONE2);
                done      <= (state_nxt == ONE2);
                if (state == ONE2)
                    count <= (count == 7'd99) ? 7'd0 : count + 7'd1;
                disp0 <= seg7(ones);
                disp1 <= seg7(tens);
            end else begin
                sig_valid <= 1'b0;
                done      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: vector table plus hand-written
// back-to-back, counter wrap and asynchronous reset sequences.
module tb_sequence_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       start;
    logic [3:0] zeros;
    logic       ready, busy, sig_out, sig_valid, done;
    logic [6:0] disp0, disp1;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int model_count = 0;

    logic [6:0] seg_tab [10];
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];

    typedef struct {
        logic       start;
        logic [3:0] zeros;
        logic       ena;
        logic [4:0] flags;  // {sig_valid, sig_out, done, ready, busy}
        logic [6:0] d0;
    } vec_t;

    vec_t vq[$];

    sequence_generator #(.ZW(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .zeros(zeros),
        .ready(ready), .busy(busy), .sig_out(sig_out), .sig_valid(sig_valid),
        .done(done), .disp0(disp0), .disp1(disp1), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic [3:0] z, input logic e,
                                input logic [4:0] f, input logic [6:0] d);
        vec_t v;
        v.start = s; v.zeros = z; v.ena = e; v.flags = f; v.d0 = d;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_disp(input string nm);
        chk({nm, "_disp0"}, 32'(disp0), 32'(seg_tab[model_count % 10]));
        chk({nm, "_disp1"}, 32'(disp1), 32'(seg_tab[model_count / 10]));
    endtask

    // One N=0 pattern from IDLE: LEAD0, ONE1, ONE2, IDLE, then display update.
    task automatic run_n0();
        start = 1'b1; zeros = 4'd0; ena = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        model_count = (model_count + 1) % 100;
    endtask

    initial begin
        bit fin;
        int dones, gaps;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

        // Vector table: inputs applied before an edge, outputs checked after it.
        // N=2 from idle, zeros change mid-pattern ignored
        vq.push_back(mk(1, 2, 1, 5'b10001, 7'h40));
        vq.push_back(mk(0, 7, 1, 5'b11001, 7'h40));
        vq.push_back(mk(0, 0, 1, 5'b10001, 7'h40));
        vq.push_back(mk(0, 0, 1, 5'b10001, 7'h40));
        vq.push_back(mk(0, 0, 1, 5'b11111, 7'h40));
        vq.push_back(mk(0, 0, 1, 5'b00010, 7'h40));
        vq.push_back(mk(0, 0, 1, 5'b00010, 7'h79));
        // N=0, start while busy ignored
        vq.push_back(mk(1, 0, 1, 5'b10001, 7'h79));
        vq.push_back(mk(1, 5, 1, 5'b11001, 7'h79));
        vq.push_back(mk(0, 0, 1, 5'b11111, 7'h79));
        vq.push_back(mk(0, 0, 1, 5'b00010, 7'h79));
        vq.push_back(mk(0, 0, 1, 5'b00010, 7'h24));
        // N=4 with stalls in ONE1, ZERO and ONE2
        vq.push_back(mk(1, 4, 1, 5'b10001, 7'h24));
        vq.push_back(mk(0, 0, 1, 5'b11001, 7'h24));
        vq.push_back(mk(0, 0, 0, 5'b01001, 7'h24));
        vq.push_back(mk(0, 0, 1, 5'b10001, 7'h24));
        vq.push_back(mk(0, 0, 0, 5'b00001, 7'h24));
        vq.push_back(mk(1, 3, 0, 5'b00001, 7'h24));
        vq.push_back(mk(0, 0, 0, 5'b00001, 7'h24));
        vq.push_back(mk(0, 0, 1, 5'b10001, 7'h24));
        vq.push_back(mk(0, 0, 1, 5'b10001, 7'h24));
        vq.push_back(mk(0, 0, 1, 5'b10001, 7'h24));
        vq.push_back(mk(0, 0, 1, 5'b11111, 7'h24));
        vq.push_back(mk(1, 2, 0, 5'b01011, 7'h24));
        vq.push_back(mk(0, 0, 1, 5'b00010, 7'h24));
        vq.push_back(mk(0, 0, 1, 5'b00010, 7'h30));

        // Reset
        rst = 1'b1; ena = 1'b0; start = 1'b0; zeros = '0;
        step(); step();
        chk("reset_flags", 32'({sig_valid, sig_out, done, ready, busy}), 32'(5'b00010));
        chk("reset_disp", 32'({disp0, disp1}), 32'({7'h40, 7'h40}));
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            start = vq[i].start; zeros = vq[i].zeros; ena = vq[i].ena;
            step();
            chk($sformatf("vec%0d", i),
                32'({sig_valid, sig_out, done, ready, busy, disp0, disp1}),
                32'({vq[i].flags, vq[i].d0, 7'h40}));
        end
        model_count = 3;

        // Back-to-back: N=15 then N=1 requested during ONE2
        exp_q.delete(); got_q.delete();
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        for (int k = 0; k < 15; k++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        fin = 1'b0; dones = 0; gaps = 0;
        start = 1'b1; zeros = 4'd15; ena = 1'b1;
        step();
        start = 1'b0; zeros = 4'd3;
        for (int c = 0; c < 60 && !fin; c++) begin
            if (sig_valid) got_q.push_back(sig_out); else gaps++;
            if (done) begin
                dones++;
                if (dones == 1) begin start = 1'b1; zeros = 4'd1; end
                else fin = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!fin) step();
        end
        start = 1'b0;
        chk("b2b_finished", 32'(fin), 32'(1));
        chk("b2b_len", 32'(got_q.size()), 32'(exp_q.size()));
        chk("b2b_gaps", 32'(gaps), 32'(0));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk($sformatf("b2b_bit%0d", k), 32'(got_q[k]), 32'(exp_q[k]));
        step(); step();
        model_count = 5;
        chk_disp("b2b");

        // Count up to 99 then wrap
        while (model_count != 99) begin
            run_n0();
            chk_disp($sformatf("cnt%0d", model_count));
        end
        chk("cnt99", 32'({disp1, disp0}), 32'({7'h18, 7'h18}));
        run_n0();
        chk("cnt_wrap", 32'({disp1, disp0}), 32'({7'h40, 7'h40}));
        run_n0();
        run_n0();
        chk_disp("cnt_after_wrap");

        // Asynchronous reset mid-ZERO, then reset dominating start
        start = 1'b1; zeros = 4'd6; ena = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("pre_rst_busy", 32'(busy), 32'(1));
        #3 rst = 1'b1;
        #1;
        chk("async_rst_flags", 32'({sig_valid, sig_out, done, ready, busy}), 32'(5'b00010));
        chk("async_rst_disp", 32'({disp0, disp1}), 32'({7'h40, 7'h40}));
        start = 1'b1; zeros = 4'd2;
        step();
        chk("rst_beats_start", 32'({sig_valid, ready, busy}), 32'(3'b010));
        start = 1'b0; rst = 1'b0;
        model_count = 0;
        step();
        chk("post_rst_idle", 32'({ready, busy}), 32'(2'b10));
        run_n0();
        chk_disp("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
